// File: rtl/laser_pkg.sv
// Shared definitions for the laser scan controller: FSM state encoding and
// default geometry/timeout parameters.
package laser_pkg;

  localparam int unsigned XY_W_DEFAULT       = 32;
  localparam int unsigned MAX_FRAMES_DEFAULT = 8;
  localparam int unsigned FRAME_CNT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SCAN = 2'd2,
    ST_HOLD = 2'd3
  } scan_state_e;

endpackage

// File: rtl/laser_frame_timer.sv
// Saturating frame counter and scan-limit compare for laser_scan_ctrl.
// The limit compare is active only when LASER_SCAN_TIMEOUT_EN is defined.
module laser_frame_timer
  import laser_pkg::*;
#(
  parameter int unsigned MAX_FRAMES = MAX_FRAMES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   inc,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   at_limit
);

  localparam logic [FRAME_CNT_W-1:0] LIMIT = FRAME_CNT_W'(MAX_FRAMES);

  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (clr) begin
      frame_cnt_d = '0;
    end else if (inc && (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;

`ifdef LASER_SCAN_TIMEOUT_EN
  assign at_limit = (frame_cnt_q == LIMIT);
`else
  // Timeout disabled: compare kept so MAX_FRAMES stays referenced, but masked off.
  assign at_limit = (frame_cnt_q == LIMIT) && 1'b0;
`endif

endmodule

// File: rtl/laser_scan_ctrl.sv
// Laser scan controller: arms the detector per frame, captures the first hit
// and holds it until acknowledged. Optional miss timeout via LASER_SCAN_TIMEOUT_EN.
module laser_scan_ctrl
  import laser_pkg::*;
#(
  parameter int unsigned MAX_FRAMES = MAX_FRAMES_DEFAULT,
  parameter int unsigned XY_W       = XY_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic            sof,
  input  logic            eof,
  input  logic            pixel_valid,
  input  logic            det_found,
  input  logic [XY_W-1:0] det_xy,
  output logic            det_en,
  output logic            det_clr,
  output logic            busy,
  output logic [XY_W-1:0] result_xy,
  output logic            result_valid,
  output logic            result_miss,
  input  logic            result_ack,
  output logic [7:0]      frame_cnt
);

  scan_state_e state_q, state_d;

  logic            det_en_q, det_en_d;
  logic            det_clr_q, det_clr_d;
  logic            busy_q, busy_d;
  logic [XY_W-1:0] result_xy_q, result_xy_d;
  logic            result_valid_q, result_valid_d;
  logic            result_miss_q, result_miss_d;

  logic frame_clr;
  logic frame_inc;
  logic at_limit;

  laser_frame_timer #(
    .MAX_FRAMES (MAX_FRAMES)
  ) u_frame_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (frame_clr),
    .inc       (frame_inc),
    .frame_cnt (frame_cnt),
    .at_limit  (at_limit)
  );

  always_comb begin
    state_d        = state_q;
    det_en_d       = 1'b0;
    det_clr_d      = 1'b0;
    result_xy_d    = result_xy_q;
    result_valid_d = result_valid_q;
    result_miss_d  = result_miss_q;
    frame_clr      = 1'b0;
    frame_inc      = 1'b0;

    if (abort) begin
      state_d        = ST_IDLE;
      result_valid_d = 1'b0;
      det_clr_d      = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_ARM;
            det_clr_d = 1'b1;
            frame_clr = 1'b1;
          end
        end
        ST_ARM: begin
          if (sof && pixel_valid) begin
            state_d   = ST_SCAN;
            frame_inc = 1'b1;
            det_en_d  = pixel_valid;
          end
        end
        ST_SCAN: begin
          // A hit in the same beat as eof takes priority over the frame boundary.
          if (det_found) begin
            state_d        = ST_HOLD;
            result_xy_d    = det_xy;
            result_valid_d = 1'b1;
            result_miss_d  = 1'b0;
          end else if (eof && pixel_valid) begin
            if (at_limit) begin
              state_d        = ST_HOLD;
              result_valid_d = 1'b1;
              result_miss_d  = 1'b1;
            end else begin
              state_d   = ST_ARM;
              det_clr_d = 1'b1;
            end
          end else begin
            det_en_d = pixel_valid;
          end
        end
        ST_HOLD: begin
          if (result_ack) begin
            state_d        = ST_IDLE;
            result_valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      det_en_q       <= 1'b0;
      det_clr_q      <= 1'b0;
      busy_q         <= 1'b0;
      result_xy_q    <= '0;
      result_valid_q <= 1'b0;
      result_miss_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      det_en_q       <= det_en_d;
      det_clr_q      <= det_clr_d;
      busy_q         <= busy_d;
      result_xy_q    <= result_xy_d;
      result_valid_q <= result_valid_d;
      result_miss_q  <= result_miss_d;
    end
  end

  assign det_en       = det_en_q;
  assign det_clr      = det_clr_q;
  assign busy         = busy_q;
  assign result_xy    = result_xy_q;
  assign result_valid = result_valid_q;
  assign result_miss  = result_miss_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Scoreboard bench for laser_scan_ctrl with MAX_FRAMES=3; the timeout scenario
// follows LASER_SCAN_TIMEOUT_EN.
module tb_laser_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sof = 1'b0;
  logic        eof = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        det_found = 1'b0;
  logic [31:0] det_xy = '0;
  logic        det_en;
  logic        det_clr;
  logic        busy;
  logic [31:0] result_xy;
  logic        result_valid;
  logic        result_miss;
  logic        result_ack = 1'b0;
  logic [7:0]  frame_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [31:0] xy;
    logic        miss;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  logic        rv_prev = 1'b0;
  logic [31:0] last_xy = '0;

  laser_scan_ctrl #(
    .MAX_FRAMES (3),
    .XY_W       (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .sof          (sof),
    .eof          (eof),
    .pixel_valid  (pixel_valid),
    .det_found    (det_found),
    .det_xy       (det_xy),
    .det_en       (det_en),
    .det_clr      (det_clr),
    .busy         (busy),
    .result_xy    (result_xy),
    .result_valid (result_valid),
    .result_miss  (result_miss),
    .result_ack   (result_ack),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic s, input logic e, input logic f, input logic [31:0] xy);
    pixel_valid = 1'b1;
    sof = s;
    eof = e;
    det_found = f;
    det_xy = xy;
    tick();
    pixel_valid = 1'b0;
    sof = 1'b0;
    eof = 1'b0;
    det_found = 1'b0;
  endtask

  task automatic push(input logic [31:0] xy, input logic miss, input logic [7:0] cnt);
    exp_t e;
    e.xy = xy;
    e.miss = miss;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  // Monitor: every rising result_valid must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1 && rv_prev !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got result_xy=%0h miss=%0b with nothing expected",
                   result_xy, result_miss);
        end else begin
          e = sb.pop_front();
          chk("sb_result_xy", 64'(result_xy), 64'(e.xy));
          chk("sb_result_miss", 64'(result_miss), 64'(e.miss));
          chk("sb_frame_cnt", 64'(frame_cnt), 64'(e.cnt));
        end
      end
      rv_prev = result_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_det_en", 64'(det_en), 64'd0);
    chk("rst_det_clr", 64'(det_clr), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_result_miss", 64'(result_miss), 64'd0);
    chk("rst_result_xy", 64'(result_xy), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    reset_n = 1'b1;
    tick();

    // Hit in frame 1
    do_start();
    chk("arm_busy", 64'(busy), 64'd1);
    chk("arm_det_clr", 64'(det_clr), 64'd1);
    chk("arm_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("arm_det_en", 64'(det_en), 64'd0);
    tick();
    chk("arm_det_clr_end", 64'(det_clr), 64'd0);
    beat(1'b1, 1'b0, 1'b0, '0);
    chk("scan_det_en", 64'(det_en), 64'd1);
    chk("scan_frame_cnt", 64'(frame_cnt), 64'd1);
    tick();
    chk("scan_det_en_idle", 64'(det_en), 64'd0);
    push(32'h0140_00F0, 1'b0, 8'd1);
    beat(1'b0, 1'b0, 1'b1, 32'h0140_00F0);
    chk("hit_valid", 64'(result_valid), 64'd1);
    chk("hold_det_en", 64'(det_en), 64'd0);
    last_xy = 32'h0140_00F0;
    tick();
    do_ack();
    chk("ack_valid", 64'(result_valid), 64'd0);
    chk("ack_busy", 64'(busy), 64'd0);
    chk("ack_xy_kept", 64'(result_xy), 64'h0140_00F0);

    // Hit coinciding with eof in frame 2; sof during SCAN ignored
    do_start();
    beat(1'b1, 1'b0, 1'b0, '0);
    beat(1'b1, 1'b0, 1'b0, '0);
    chk("sof_in_scan_ignored", 64'(frame_cnt), 64'd1);
    beat(1'b0, 1'b1, 1'b0, '0);
    chk("eof_det_clr", 64'(det_clr), 64'd1);
    chk("eof_det_en", 64'(det_en), 64'd0);
    chk("eof_busy", 64'(busy), 64'd1);
    beat(1'b1, 1'b0, 1'b0, '0);
    chk("f2_frame_cnt", 64'(frame_cnt), 64'd2);
    push(32'h0200_0100, 1'b0, 8'd2);
    beat(1'b0, 1'b1, 1'b1, 32'h0200_0100);
    chk("hit_eof_no_clr", 64'(det_clr), 64'd0);
    chk("hit_eof_valid", 64'(result_valid), 64'd1);
    last_xy = 32'h0200_0100;
    do_ack();

    // Three frames without a hit
    do_start();
    for (int f = 1; f <= 3; f++) begin
      beat(1'b1, 1'b0, 1'b0, '0);
      chk("to_frame_cnt", 64'(frame_cnt), 64'(f));
`ifdef LASER_SCAN_TIMEOUT_EN
      if (f == 3) push(last_xy, 1'b1, 8'd3);
`endif
      beat(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      if (f < 3) begin
        chk("to_det_clr", 64'(det_clr), 64'd1);
      end
    end
`ifdef LASER_SCAN_TIMEOUT_EN
    chk("to_no_clr", 64'(det_clr), 64'd0);
    chk("to_valid", 64'(result_valid), 64'd1);
    chk("to_miss", 64'(result_miss), 64'd1);
    chk("to_xy_kept", 64'(result_xy), 64'(last_xy));
    do_ack();
`else
    chk("nto_det_clr", 64'(det_clr), 64'd1);
    chk("nto_valid", 64'(result_valid), 64'd0);
    chk("nto_busy", 64'(busy), 64'd1);
    beat(1'b1, 1'b0, 1'b0, '0);
    chk("nto_frame_cnt", 64'(frame_cnt), 64'd4);
    push(32'h0003_0004, 1'b0, 8'd4);
    beat(1'b0, 1'b0, 1'b1, 32'h0003_0004);
    chk("nto_miss", 64'(result_miss), 64'd0);
    last_xy = 32'h0003_0004;
    do_ack();
`endif

    // Abort during SCAN; abort with start in IDLE
    do_start();
    beat(1'b1, 1'b0, 1'b0, '0);
    abort = 1'b1;
    pixel_valid = 1'b1;
    tick();
    abort = 1'b0;
    pixel_valid = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_det_en", 64'(det_en), 64'd0);
    chk("abort_valid", 64'(result_valid), 64'd0);
    chk("abort_det_clr", 64'(det_clr), 64'd1);
    tick();
    chk("abort_det_clr_end", 64'(det_clr), 64'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", 64'(busy), 64'd0);
    chk("abort_idle_no_clr", 64'(det_clr), 64'd0);
    tick();
    chk("abort_start_ignored", 64'(busy), 64'd0);

    // result_ack outside HOLD ignored
    result_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ack_in_arm_busy", 64'(busy), 64'd1);
    tick();
    chk("ack_in_arm_busy2", 64'(busy), 64'd1);
    result_ack = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Long hold with start pulses
    do_start();
    beat(1'b1, 1'b0, 1'b0, '0);
    push(32'h0055_00AA, 1'b0, 8'd1);
    beat(1'b0, 1'b0, 1'b1, 32'h0055_00AA);
    for (int i = 0; i < 100; i++) begin
      start = (i % 10 == 0);
      det_xy = 32'h1111_2222;
      tick();
      start = 1'b0;
      chk("hold_stable", {27'd0, result_valid, busy, det_en, result_miss, det_clr, result_xy},
          {27'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0055_00AA});
    end
    do_ack();
    chk("hold_ack_busy", 64'(busy), 64'd0);

    // Reset mid-scan overrides a coincident hit
    do_start();
    beat(1'b1, 1'b0, 1'b0, '0);
    pixel_valid = 1'b1;
    eof = 1'b1;
    det_found = 1'b1;
    det_xy = 32'h7777_8888;
    reset_n = 1'b0;
    tick();
    pixel_valid = 1'b0;
    eof = 1'b0;
    det_found = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_det_en", 64'(det_en), 64'd0);
    chk("mrst_det_clr", 64'(det_clr), 64'd0);
    chk("mrst_valid", 64'(result_valid), 64'd0);
    chk("mrst_miss", 64'(result_miss), 64'd0);
    chk("mrst_xy", 64'(result_xy), 64'd0);
    chk("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("mrst_after_busy", 64'(busy), 64'd0);
    chk("mrst_after_det_clr", 64'(det_clr), 64'd0);
    tick();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
